return_addr_stack: RTL and testbench
====================================

# return_addr_stack

Return-address stack for the 16-bit pipelined processor: the consumer side of the EX-stage link path. A link instruction (JAL) pushes its return address (PC of the following instruction) into a circular LIFO. A return instruction (JR R7) pops that address, so fetch can redirect speculatively without waiting for R7 writeback. It sits beside the ID stage, and its output feeds the PC-select logic.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- WIDTH, 16, address width in bits
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Flush  input  1  clears the stack (pipeline flush / exception)
- Push  input  1  link instruction accepted this cycle
- PushAddr  input  WIDTH  return address to store when Push=1
- Pop  input  1  return instruction accepted this cycle
- TopAddr  output  WIDTH  predicted return address (current top entry)
- Valid  output  1  stack non-empty; TopAddr meaningful
- Count  output  $clog2(DEPTH+1)  number of valid entries
- Overflow  output  1  one-cycle pulse: push while full overwrote the oldest entry
- Underflow  output  1  one-cycle pulse: pop while empty

## Operation
- Storage: DEPTH×WIDTH register array, TOS pointer of $clog2(DEPTH) bits, and Count register.
- Per-cycle command priority: Flush > (Push & Pop) > Push > Pop > idle.
- Flush: Count←0, TOS←0. Array contents are not cleared. Push and Pop are ignored that cycle. No Overflow/Underflow pulse.
- Push only:
  - TOS←TOS+1 mod DEPTH, then entry[new TOS]←PushAddr.
  - Count←Count+1, saturating at DEPTH.
  - If Count==DEPTH before the push, the oldest entry is overwritten (wrap-around) and Overflow=1 for one cycle.
- Pop only:
  - If Count>0: TOS←TOS−1 mod DEPTH and Count←Count−1.
  - If Count==0: no state change and Underflow=1 for one cycle.
- Push & Pop together (JR-and-link or back-to-back):
  - If Count>0: entry[TOS]←PushAddr (replace top). TOS and Count are unchanged. No pulses.
  - If Count==0: behaves as Push only, giving Count=1. No Underflow.
- TopAddr = entry[TOS] when Count>0, else all zeros. Valid = (Count!=0).
- Pointer arithmetic is modulo DEPTH. No width extension is needed because DEPTH is a power of two.

## Timing
- Reset (Reset_n=0, asynchronous): Count=0, TOS=0, all array entries=0, TopAddr=16'h0000, Valid=0, Overflow=0, Underflow=0. Deassertion takes effect at the next rising edge.
- Reset mid-operation discards all entries immediately. There is no partial-update state.
- All state updates occur on the rising Clk edge.
- Outputs derive from registers only. TopAddr/Valid/Count reflect a push or pop one cycle after the sampling edge, i.e. valid for the whole next cycle.
- Overflow/Underflow are registered and assert in the cycle after the offending command, for exactly one cycle.
- Push and Pop may be asserted every cycle with no bubbles. There is no backpressure and no handshake.
- The value popped is the TopAddr visible during the Pop cycle. Consumers sample TopAddr in the same cycle they assert Pop.

## Test plan
- Reset / basic LIFO: after reset, TopAddr=0000, Valid=0, Count=0. Push 1111, 2222, 3333 on consecutive cycles -> TopAddr=3333, Count=3. Pop -> TopAddr=2222. Pop -> TopAddr=1111. Pop -> Valid=0, TopAddr=0000.
- Overflow wrap (DEPTH=8): push 0001..0009 -> Overflow pulses once, after the 9th push; Count=8; TopAddr=0009. Eight pops return 0009 down to 0002, then Valid=0. Entry 0001 is lost.
- Underflow: from empty, Pop -> Underflow=1 for one cycle; Count stays 0; TopAddr=0000. Next cycle Underflow=0.
- Simultaneous: with stack holding AAAA, BBBB (top=BBBB), Push+Pop with PushAddr=CCCC -> TopAddr=CCCC, Count=2. Pop -> AAAA. From empty, Push+Pop with 1234 -> Count=1, TopAddr=1234, no Underflow.
- Flush priority: with Count=3, assert Flush+Push (PushAddr=FFFF) -> Count=0, Valid=0, no pulses. A following Push of 5555 -> TopAddr=5555, Count=1.
- Asynchronous reset mid-stream: with Count=5, drop Reset_n between clock edges -> all outputs return to reset values immediately, without waiting for an edge. After release, a Push of 0F0F gives Count=1, TopAddr=0F0F.

Source files
------------

// File: rtl/return_addr_stack_if.sv
// Return-address stack command/prediction bundle.
// The master side issues link/return commands; the slave side (the stack)
// presents the predicted return address and the occupancy status.
interface return_addr_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] push_addr;
  logic             pop;
  logic [WIDTH-1:0] top_addr;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, push_addr, pop,
    input  top_addr, valid, count, overflow, underflow
  );

  modport slave (
    input  flush, push, push_addr, pop,
    output top_addr, valid, count, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Return-address stack: circular LIFO of link addresses used to predict the
// target of a return so fetch can redirect before the link register is
// written back. When full, a push silently replaces the oldest entry.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  return_addr_stack_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_FLUSH,
    CMD_REPLACE,
    CMD_PUSH,
    CMD_POP
  } cmd_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] cnt;
  logic             overflow_q;
  logic             underflow_q;

  cmd_e             cmd;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  // Pointer wrap is implicit: DEPTH is a power of two.
  assign tos_inc = tos + PTR_W'(1);
  assign tos_dec = tos - PTR_W'(1);

  // Resolve the cycle's command: flush wins, then push+pop, push, pop.
  always_comb begin
    // NOTE: default first so every path assigns cmd and no latch is inferred.
    cmd = CMD_IDLE;
    if (bus.flush)
      cmd = CMD_FLUSH;
    else if (bus.push && bus.pop && !empty)
      cmd = CMD_REPLACE;              // return-and-link: swap the top entry
    else if (bus.push)
      cmd = CMD_PUSH;                 // includes push+pop on an empty stack
    else if (bus.pop)
      cmd = CMD_POP;
  end

  // Stack state, storage and the one-cycle overflow/underflow pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos         <= '0;
      cnt         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      // NOTE: storage is cleared on reset because stale addresses must never
      // be predicted; this costs a reset on every entry flop.
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      unique case (cmd)
        CMD_FLUSH: begin
          // Entries are left in place; count=0 makes them unreachable.
          tos <= '0;
          cnt <= '0;
        end
        CMD_REPLACE: begin
          mem[tos] <= bus.push_addr;
        end
        CMD_PUSH: begin
          tos          <= tos_inc;
          mem[tos_inc] <= bus.push_addr;
          if (full)
            overflow_q <= 1'b1;       // oldest entry was overwritten
          else
            cnt <= cnt + CNT_W'(1);
        end
        CMD_POP: begin
          if (empty) begin
            underflow_q <= 1'b1;
          end else begin
            tos <= tos_dec;
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers; top reads as zero when empty.
  always_comb begin
    bus.top_addr  = empty ? '0 : mem[tos];
    bus.valid     = !empty;
    bus.count     = cnt;
    bus.overflow  = overflow_q;
    bus.underflow = underflow_q;
  end
endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack. The driver issues one command per
// cycle, advances a queue-based LIFO model and queues the outputs expected
// after the next edge; an independent monitor pops and compares them.
module tb_return_addr_stack;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic clk;
  logic reset_n;

  return_addr_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  return_addr_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] top;
    logic             valid;
    logic [3:0]       count;
    logic             ov;
    logic             un;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_q[$];   // back of queue is the top of the stack
  int               vectors    = 0;
  int               miscompares = 0;
  event             async_chk;

  // Compare the DUT outputs against one queued expectation.
  task automatic check(input exp_t e);
    vectors++;
    if (bus.top_addr !== e.top || bus.valid !== e.valid ||
        bus.count !== e.count || bus.overflow !== e.ov ||
        bus.underflow !== e.un) begin
      miscompares++;
      $display("FAIL %s @%0t: got top=%h valid=%b count=%0d ov=%b un=%b, expected top=%h valid=%b count=%0d ov=%b un=%b",
               e.tag, $time, bus.top_addr, bus.valid, bus.count, bus.overflow,
               bus.underflow, e.top, e.valid, e.count, e.ov, e.un);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, or right after an async reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or async_chk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  task automatic push_exp(input string tag, input logic ov, input logic un);
    exp_t e;
    e.top   = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
    e.valid = (model_q.size() > 0);
    e.count = 4'(model_q.size());
    e.ov    = ov;
    e.un    = un;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Issue one command for the coming edge and queue its expected outcome.
  task automatic drive(input logic f, input logic pu, input logic [WIDTH-1:0] a,
                       input logic po, input string tag);
    logic ov, un;
    logic [WIDTH-1:0] dropped;
    @(negedge clk);
    #1;
    bus.flush = f; bus.push = pu; bus.push_addr = a; bus.pop = po;
    ov = 1'b0; un = 1'b0;
    if (f) begin
      model_q.delete();
    end else if (pu && po && model_q.size() > 0) begin
      model_q[model_q.size() - 1] = a;
    end else if (pu) begin
      model_q.push_back(a);
      if (model_q.size() > DEPTH) begin
        dropped = model_q.pop_front();
        ov = 1'b1;
      end
    end else if (po) begin
      if (model_q.size() > 0) dropped = model_q.pop_back();
      else un = 1'b1;
    end
    push_exp(tag, ov, un);
  endtask

  task automatic push_op(input logic [WIDTH-1:0] a, input string tag);
    drive(1'b0, 1'b1, a, 1'b0, tag);
  endtask

  task automatic pop_op(input string tag);
    drive(1'b0, 1'b0, '0, 1'b1, tag);
  endtask

  task automatic idle_op(input string tag);
    drive(1'b0, 1'b0, '0, 1'b0, tag);
  endtask

  // Drop reset between edges and expect reset outputs without a clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = '0;
    #1;
    model_q.delete();
    push_exp(tag, 1'b0, 1'b0);
    -> async_chk;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    push_exp("reset", 1'b0, 1'b0);
    -> async_chk;
    #1;
    reset_n = 1'b1;

    // Basic LIFO order
    push_op(16'h1111, "lifo_push1");
    push_op(16'h2222, "lifo_push2");
    push_op(16'h3333, "lifo_push3");
    pop_op("lifo_pop3");
    pop_op("lifo_pop2");
    pop_op("lifo_pop1");
    idle_op("lifo_idle");

    // Overflow wrap: the ninth push drops 0001
    for (int i = 1; i <= 9; i++) push_op(16'(i), "ovf_push");
    idle_op("ovf_idle");
    for (int i = 0; i < 8; i++) pop_op("ovf_pop");
    idle_op("ovf_empty");

    // Underflow from empty
    pop_op("udf_pop");
    idle_op("udf_clear");

    // Simultaneous push+pop
    push_op(16'hAAAA, "sim_push_a");
    push_op(16'hBBBB, "sim_push_b");
    drive(1'b0, 1'b1, 16'hCCCC, 1'b1, "sim_replace");
    pop_op("sim_pop_to_a");
    pop_op("sim_pop_empty");
    drive(1'b0, 1'b1, 16'h1234, 1'b1, "sim_empty_pushpop");
    pop_op("sim_pop_1234");

    // Flush beats push
    push_op(16'h0101, "fl_push1");
    push_op(16'h0202, "fl_push2");
    push_op(16'h0303, "fl_push3");
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0, "fl_flush_push");
    push_op(16'h5555, "fl_push_after");
    pop_op("fl_pop");
    pop_op("fl_pop_empty");

    // Asynchronous reset mid-stream with five entries
    for (int i = 0; i < 5; i++) push_op(16'hE000 + 16'(i), "ar_fill");
    async_reset("async_reset");
    push_op(16'h0F0F, "ar_push_after");
    drive(1'b1, 1'b0, '0, 1'b0, "ar_flush");

    // Randomized traffic: push-heavy phase, then pop-heavy phase
    for (int n = 0; n < 600; n++) begin
      int r;
      int push_pct;
      r = int'($urandom_range(0, 99));
      push_pct = (n < 300) ? 60 : 25;
      if (r < 3)
        drive(1'b1, $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, "rnd_flush");
      else if (r < 18)
        drive(1'b0, 1'b1, 16'($urandom), 1'b1, "rnd_pushpop");
      else if (r < 18 + push_pct)
        push_op(16'($urandom), "rnd_push");
      else if (r < 95)
        pop_op("rnd_pop");
      else
        idle_op("rnd_idle");
    end
    idle_op("final_idle");

    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
